// File: rtl/relay_rx_framer_pkg.sv
// relay_rx_framer_pkg: mode codes, comm markers, FSM states and marker matchers for the relay receive path
package relay_rx_framer_pkg;

   localparam logic [2:0] SNIFFER       = 3'b000;
   localparam logic [2:0] TAGSIM_LISTEN = 3'b001;
   localparam logic [2:0] TAGSIM_MOD    = 3'b010;
   localparam logic [2:0] READER_LISTEN = 3'b011;
   localparam logic [2:0] READER_MOD    = 3'b100;
   localparam logic [2:0] FAKE_READER   = 3'b101;
   localparam logic [2:0] FAKE_TAG      = 3'b110;

   localparam logic [7:0]  READER_START_COMM = 8'hc0;
   localparam logic [31:0] READER_END_COMM_1 = 32'h0000_0000;
   localparam logic [31:0] READER_END_COMM_2 = 32'hc000_0000;
   localparam logic [7:0]  TAG_START_COMM    = 8'hf0;
   localparam logic [23:0] TAG_END_COMM      = 24'h000000;

   typedef enum logic [1:0] {IDLE, HUNT, ACTIVE} state_t;

   function automatic logic is_fake(input logic [2:0] m);
      return m == FAKE_READER || m == FAKE_TAG;
   endfunction

   function automatic logic [2:0] listen_of(input logic [2:0] m);
      return m == FAKE_READER ? READER_LISTEN : TAGSIM_LISTEN;
   endfunction

   function automatic logic [2:0] mod_of(input logic [2:0] m);
      return m == FAKE_READER ? READER_MOD : TAGSIM_MOD;
   endfunction

   // start marker is a full byte preceded by two silent bytes
   function automatic logic start_match(input logic reader, input logic [31:0] sh);
      return sh[23:0] == {16'h0000, reader ? READER_START_COMM : TAG_START_COMM};
   endfunction

   function automatic logic end_match(input logic reader, input logic [31:0] sh);
      return reader ? (sh == READER_END_COMM_1 || sh == READER_END_COMM_2) : sh[23:0] == TAG_END_COMM;
   endfunction

endpackage

// File: rtl/relay_rx_framer_bit_sampler.sv
// relay_bit_sampler: synchronises the relay line and emits one sample per bit period (RELAY_RX_MAJORITY_EN selects 2-of-3 voting)
module relay_bit_sampler #(
   parameter int DIV_LOG2     = 4,
   parameter int SAMPLE_PHASE = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic line,
   output logic s,
   output logic tick
);

   logic [1:0]          sync;
   logic [DIV_LOG2-1:0] div;

   // two-flop synchroniser and free-running bit-period divider
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync <= '0;
         div  <= '0;
      end else begin
         sync <= {sync[0], line};
         div  <= div + 1'b1;
      end

`ifdef RELAY_RX_MAJORITY_EN
   logic early, mid;

   // hold the two samples that precede the voting point
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         early <= 1'b0;
         mid   <= 1'b0;
      end else begin
         if (div == DIV_LOG2'(SAMPLE_PHASE - 1)) early <= sync[1];
         if (div == DIV_LOG2'(SAMPLE_PHASE)) mid <= sync[1];
      end

   assign tick = div == DIV_LOG2'(SAMPLE_PHASE + 1);
   assign s    = (early & mid) | (early & sync[1]) | (mid & sync[1]);
`else
   assign tick = div == DIV_LOG2'(SAMPLE_PHASE);
   assign s    = sync[1];
`endif

endmodule

// File: rtl/relay_rx_framer.sv
// relay_rx_framer: relay-line framer resolving mod_type for hi_iso14443a (sampler option RELAY_RX_MAJORITY_EN)
module relay_rx_framer
   import relay_rx_framer_pkg::*;
#(
   parameter int DIV_LOG2     = 4,
   parameter int SAMPLE_PHASE = 8,
   parameter int TIMEOUT_BITS = 255
) (
   input  logic       ck_1356meg,
   input  logic       rst,
   input  logic [2:0] sim_mode,
   input  logic       relay_in,
   output logic [2:0] mod_type,
   output logic       data_bit,
   output logic       data_valid,
   output logic       in_frame,
   output logic       frame_start,
   output logic       frame_end,
   output logic       timeout_err
);

   localparam int TW = $clog2(TIMEOUT_BITS + 1);

   logic          s, tick, reader, changed, tmo, fin;
   logic [31:0]   shift;
   logic [2:0]    bit_cnt, last_mode;
   logic [TW-1:0] timer;
   state_t        state;

   relay_bit_sampler #(.DIV_LOG2(DIV_LOG2), .SAMPLE_PHASE(SAMPLE_PHASE)) u_sampler (
      .clk (ck_1356meg),
      .rst (rst),
      .line(relay_in),
      .s   (s),
      .tick(tick)
   );

   // marker decisions look at the shift register one clock after the tick that loaded it
   always_comb begin
      reader  = sim_mode == FAKE_READER;
      changed = sim_mode != last_mode;
      tmo     = timer == TW'(TIMEOUT_BITS - 1);
      fin     = tmo || (bit_cnt == 3'd0 && end_match(reader, shift));
   end

   // sample shifting, mode-change restart and IDLE/HUNT/ACTIVE framing with registered outputs
   always_ff @(posedge ck_1356meg or posedge rst)
      if (rst) begin
         state       <= IDLE;
         shift       <= '0;
         bit_cnt     <= '0;
         timer       <= '0;
         last_mode   <= SNIFFER;
         mod_type    <= SNIFFER;
         data_bit    <= 1'b0;
         data_valid  <= 1'b0;
         in_frame    <= 1'b0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         last_mode   <= sim_mode;
         data_valid  <= tick && !changed;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
         timeout_err <= 1'b0;
         if (tick) begin
            shift    <= {shift[30:0], s};
            bit_cnt  <= bit_cnt + 3'd1;
            data_bit <= shift[14];
         end
         if (changed) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            timer    <= '0;
            in_frame <= 1'b0;
            mod_type <= is_fake(sim_mode) ? listen_of(sim_mode) : sim_mode;
         end else begin
            case (state)
               IDLE: begin
                  state    <= is_fake(sim_mode) ? HUNT : IDLE;
                  mod_type <= is_fake(sim_mode) ? listen_of(sim_mode) : sim_mode;
               end
               HUNT:
                  if (data_valid && start_match(reader, shift)) begin
                     state       <= ACTIVE;
                     mod_type    <= mod_of(sim_mode);
                     bit_cnt     <= '0;
                     timer       <= '0;
                     in_frame    <= 1'b1;
                     frame_start <= 1'b1;
                  end
               ACTIVE:
                  if (data_valid) begin
                     timer <= timer + 1'b1;
                     if (fin) begin
                        state       <= HUNT;
                        mod_type    <= listen_of(sim_mode);
                        in_frame    <= 1'b0;
                        frame_end   <= 1'b1;
                        timeout_err <= tmo;
                     end
                  end
               default: state <= IDLE;
            endcase
         end
      end

endmodule

// File: tb/tb_relay_rx_framer.sv
// tb_relay_rx_framer: randomized bit-stream bench with a frame-level reference model
module tb_relay_rx_framer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] sim_mode = 3'b000;
   logic       relay_in = 1'b0;
   logic [2:0] mod_type;
   logic       data_bit, data_valid, in_frame, frame_start, frame_end, timeout_err;

   int n_cmp = 0;
   int n_err = 0;

   bit         hist[$];
   bit         m_active = 1'b0;
   int         m_nb = 0;
   logic [2:0] m_mode = 3'b000;
   bit         fast = 1'b0;

   relay_rx_framer dut (
      .ck_1356meg (clk),
      .rst        (rst),
      .sim_mode   (sim_mode),
      .relay_in   (relay_in),
      .mod_type   (mod_type),
      .data_bit   (data_bit),
      .data_valid (data_valid),
      .in_frame   (in_frame),
      .frame_start(frame_start),
      .frame_end  (frame_end),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] last_bits(input int n);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) begin
         int k = hist.size() - n + i;
         v = (v << 1) | ((k >= 0) ? 32'(hist[k]) : 32'd0);
      end
      return v;
   endfunction

   function automatic logic [2:0] exp_mod();
      if (m_mode != 3'b101 && m_mode != 3'b110) return m_mode;
      if (m_mode == 3'b101) return m_active ? 3'b100 : 3'b011;
      return m_active ? 3'b010 : 3'b001;
   endfunction

   task automatic set_mode(input logic [2:0] m);
      sim_mode = m;
      m_mode   = m;
      hist.delete();
      m_active = 1'b0;
      fast     = 1'b1;
   endtask

   // one bit period, starting at the falling edge where the divider reads 0
   task automatic send_bit(input bit b, input bit glitch = 1'b0);
      int dv = 0, fs = 0, fe = 0, te = 0, dv_at = -1, fs_at = -1;
      bit s, fake, reader, x_fs = 0, x_fe = 0, x_te = 0;
      relay_in = b;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (glitch && i == 5) relay_in = ~b;
         if (glitch && i == 6) relay_in = b;
         if (fast && i == 1) begin
            check("mode_fast", 32'(mod_type), 32'(exp_mod()));
            fast = 1'b0;
         end
         dv += int'(data_valid);
         fs += int'(frame_start);
         fe += int'(frame_end);
         te += int'(timeout_err);
         if (data_valid) dv_at = i;
         if (frame_start) fs_at = i;
      end
`ifdef RELAY_RX_MAJORITY_EN
      s = b;
`else
      s = glitch ? ~b : b;
`endif
      hist.push_back(s);
      fake   = m_mode == 3'b101 || m_mode == 3'b110;
      reader = m_mode == 3'b101;
      if (fake && !m_active) begin
         if (last_bits(24) == (reader ? 32'h0000C0 : 32'h0000F0)) begin
            m_active = 1'b1;
            m_nb     = 0;
            x_fs     = 1'b1;
         end
      end else if (fake) begin
         m_nb++;
         x_te = m_nb == 255;
         x_fe = x_te || (m_nb % 8 == 0 &&
                (reader ? (last_bits(32) == 32'h0 || last_bits(32) == 32'hC000_0000) : last_bits(24) == 32'h0));
         if (x_fe) m_active = 1'b0;
      end
      check("data_valid", 32'(dv), 32'd1);
      check("frame_start", 32'(fs), 32'(x_fs));
      check("frame_end", 32'(fe), 32'(x_fe));
      check("timeout_err", 32'(te), 32'(x_te));
      if (x_fs) check("start_latency", 32'(fs_at), 32'(dv_at + 1));
      check("mod_type", 32'(mod_type), 32'(exp_mod()));
      check("in_frame", 32'(in_frame), 32'(m_active));
      check("data_bit", 32'(data_bit), hist.size() >= 16 ? 32'(hist[hist.size() - 16]) : 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic open_frame(input bit reader);
      repeat (16) send_bit(1'b0);
      send_byte(reader ? 8'hC0 : 8'hF0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_mod_type"}, 32'(mod_type), 32'd0);
      check({tag, "_pulses"}, 32'({data_bit, data_valid, in_frame, frame_start, frame_end, timeout_err}), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      set_mode(3'b011);
      repeat (20) send_bit(1'($urandom_range(0, 1)));
      repeat (4) send_bit(1'b0, 1'b1);
      repeat (4) send_bit(1'b1, 1'b1);
      repeat (16) send_bit(1'($urandom_range(0, 1)));
      for (int r = 0; r < 2; r++) begin
         set_mode(r == 0 ? 3'b101 : 3'b110);
         open_frame(r == 0);
         repeat (3) send_byte(8'($urandom_range(1, 255)));
         repeat (24) send_bit(1'b0);
         open_frame(r == 0);
         send_byte(8'($urandom_range(1, 255)));
         repeat (3) send_bit(1'b1);
         repeat (40) send_bit(1'b0);
         repeat (24) send_bit(1'($urandom_range(0, 1)));
         open_frame(r == 0);
         for (int i = 0; i < 260; i++) send_bit(i % 2 == 0);
         open_frame(r == 0);
         repeat (5) send_bit(1'($urandom_range(0, 1)));
         set_mode(3'b000);
         repeat (3) send_bit(1'($urandom_range(0, 1)));
      end
      set_mode(3'b101);
      open_frame(1'b1);
      repeat (6) send_bit(1'b1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_zero("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      hist.delete();
      m_active = 1'b0;
      fast = 1'b1;
      open_frame(1'b1);
      repeat (24) send_bit(1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
